// File: rtl/jtag_scan_master.sv
// JTAG TAP initiator: runs IR/DR scans on tck/tms/tdi and returns the captured tdo bits.
// Latency: a scan takes 2*DIV*(hdr + N + 2) clk from command accept to rsp_valid, where hdr is 4 for IR and 3 for DR.
// Backpressure: cmd_ready is high only in IDLE; a response is held until rsp_ready, which blocks further commands.
module jtag_scan_master #(
  parameter int DATA_W = 38,
  parameter int LEN_W  = 6,
  parameter int DIV    = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_ir,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              tck,
  output logic              tms,
  output logic              tdi,
  input  logic              tdo
);

  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0]    DIV_LAST = DW'(DIV - 1);
  localparam logic [LEN_W-1:0] LAST_MAX = LEN_W'(DATA_W - 1);

  typedef enum logic [2:0] {S_INIT, S_IDLE, S_HDR, S_SHIFT, S_TAIL, S_RESP} state_e;

  state_e            state_q, state_d;
  logic [DW-1:0]     div_q, div_d;
  logic              tck_q, tck_d;
  logic              tms_q, tms_d;
  logic              tdi_q, tdi_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [LEN_W-1:0]  len_q, len_d;     // index of the last shift bit (length - 1)
  logic              ir_q, ir_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] rsp_q, rsp_d;

  logic             toggling, phase_end, fall_ev, samp_ev, tdo_s;
  logic [LEN_W-1:0] cnt_inc, hdr_last;

  assign toggling  = (state_q == S_INIT) || (state_q == S_HDR) ||
                     (state_q == S_SHIFT) || (state_q == S_TAIL);
  assign phase_end = (div_q == DIV_LAST);
  assign fall_ev   = toggling && phase_end && tck_q;
  assign cnt_inc   = cnt_q + LEN_W'(1);
  assign hdr_last  = ir_q ? LEN_W'(3) : LEN_W'(2);

  // tdo capture point. With a synchroniser, the value read two clk after the rising
  // tck edge is exactly tdo as it stood at that edge, so the sample is taken then.
  if (DIV >= 2) begin : g_sync
    logic sync1_q, sync2_q;

    // Two-flop synchroniser for the asynchronous tdo pin.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        sync1_q <= 1'b0;
        sync2_q <= 1'b0;
      end else begin
        sync1_q <= tdo;
        sync2_q <= sync1_q;
      end
    end

    assign tdo_s   = sync2_q;
    assign samp_ev = (state_q == S_SHIFT) && tck_q && (div_q == DW'(1));
  end else begin : g_nosync
    assign tdo_s   = tdo;
    assign samp_ev = (state_q == S_SHIFT) && phase_end && !tck_q;
  end

  // Next-state logic: tck divider, TAP walk sequencing and tdo capture.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    ir_d    = ir_q;
    data_d  = data_q;
    tms_d   = tms_q;
    tdi_d   = tdi_q;
    rsp_d   = rsp_q;
    tck_d   = 1'b0;
    div_d   = '0;

    if (toggling) begin
      if (phase_end) begin
        tck_d = ~tck_q;
      end else begin
        tck_d = tck_q;
        div_d = div_q + DW'(1);
      end
    end

    if (samp_ev) rsp_d[cnt_q] = tdo_s;

    case (state_q)
      S_INIT: begin
        // five tms=1 cycles reach Test-Logic-Reset from anywhere, the sixth (tms=0) parks in Run-Test/Idle
        if (fall_ev) begin
          if (cnt_q == LEN_W'(5)) begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
            tms_d = (cnt_inc != LEN_W'(5));
          end
        end
      end
      S_IDLE: begin
        if (cmd_valid) begin
          state_d = S_HDR;
          ir_d    = cmd_ir;
          data_d  = cmd_data;
          len_d   = (cmd_len > LAST_MAX) ? LAST_MAX : cmd_len;
          rsp_d   = '0;
          cnt_d   = '0;
          tms_d   = 1'b1;
          tdi_d   = 1'b0;
        end
      end
      S_HDR: begin
        // IR walk tms 1,1,0,0; DR walk tms 1,0,0
        if (fall_ev) begin
          if (cnt_q == hdr_last) begin
            state_d = S_SHIFT;
            cnt_d   = '0;
            tms_d   = (len_q == '0);
            tdi_d   = data_q[0];
          end else begin
            cnt_d = cnt_inc;
            tms_d = ir_q ? (cnt_inc < LEN_W'(2)) : 1'b0;
          end
        end
      end
      S_SHIFT: begin
        // data_q is consumed LSB first; the last bit carries tms=1 into Exit1
        if (fall_ev) begin
          if (cnt_q == len_q) begin
            state_d = S_TAIL;
            cnt_d   = '0;
            tms_d   = 1'b1;
            tdi_d   = 1'b0;
          end else begin
            cnt_d  = cnt_inc;
            data_d = data_q >> 1;
            tdi_d  = data_q[1];
            tms_d  = (cnt_inc == len_q);
          end
        end
      end
      S_TAIL: begin
        // Update (tms=1) then back to Run-Test/Idle (tms=0)
        if (fall_ev) begin
          if (cnt_q != '0) begin
            state_d = S_RESP;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
            tms_d = 1'b0;
          end
        end
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_INIT;
    endcase
  end

  // State registers; reset restarts the TAP walk from INIT at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_INIT;
      div_q   <= '0;
      tck_q   <= 1'b0;
      tms_q   <= 1'b1;
      tdi_q   <= 1'b0;
      cnt_q   <= '0;
      len_q   <= '0;
      ir_q    <= 1'b0;
      data_q  <= '0;
      rsp_q   <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      tck_q   <= tck_d;
      tms_q   <= tms_d;
      tdi_q   <= tdi_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      ir_q    <= ir_d;
      data_q  <= data_d;
      rsp_q   <= rsp_d;
    end
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_data  = rsp_q;
  assign tck       = tck_q;
  assign tms       = tms_q;
  assign tdi       = tdi_q;

endmodule

// File: tb/tb_jtag_scan_master.sv
// Bench for jtag_scan_master: IEEE 1149.1 TAP model on the pins plus a queued scoreboard.
// Expected responses are queued at command issue and checked by an independent monitor.
// rsp_ready is randomised, held low or forced high to exercise response backpressure.
module tb_jtag_scan_master;

  localparam int DATA_W = 38;
  localparam int LEN_W  = 6;
  localparam int DIV    = 2;
  localparam int CLK_P  = 10;

  typedef enum int {TLR, RTI, SELDR, CAPDR, SHDR, EX1DR, PAUSEDR, EX2DR, UPDDR,
                    SELIR, CAPIR, SHIR, EX1IR, PAUSEIR, EX2IR, UPDIR} tap_e;

  typedef struct {
    logic [DATA_W-1:0] rsp;
    logic [DATA_W-1:0] tdi_bits;
    bit                ir;
    int                n;
    int                tcks;
  } exp_t;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              cmd_valid = 1'b0;
  logic              cmd_ir = 1'b0;
  logic [LEN_W-1:0]  cmd_len = '0;
  logic [DATA_W-1:0] cmd_data = '0;
  logic              rsp_ready = 1'b0;
  logic              cmd_ready, rsp_valid, tck, tms, tdi, tdo;
  logic [DATA_W-1:0] rsp_data;

  int n_chk = 0;
  int n_pass = 0;

  exp_t   exp_q[$];
  tap_e   tap = PAUSEDR;
  int     sh_cnt = 0;
  bit     sh_ir = 1'b0;
  logic [DATA_W-1:0] sh_bits = '0;
  logic   tms_log[$];
  time    rise_t[$];
  int     tck_rises = 0;
  int     start_tck = 0;
  time    start_t = 0;
  int     tdo_mode = 0;       // 0: loopback to tdi, 1: constant 1, 2: per-bit pattern
  logic [DATA_W-1:0] tdo_pat = '0;
  logic   tdo_r = 1'b0;
  int     rdy_mode = 2;       // 0: random, 1: held low, 2: held high

  assign tdo = (tdo_mode == 0) ? tdi : tdo_r;

  jtag_scan_master #(.DATA_W(DATA_W), .LEN_W(LEN_W), .DIV(DIV)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ir(cmd_ir),
    .cmd_len(cmd_len), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .tck(tck), .tms(tms), .tdi(tdi), .tdo(tdo)
  );

  always #(CLK_P/2) clk = ~clk;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic tap_e tap_next(input tap_e s, input logic m);
    case (s)
      TLR:     return m ? TLR   : RTI;
      RTI:     return m ? SELDR : RTI;
      SELDR:   return m ? SELIR : CAPDR;
      CAPDR:   return m ? EX1DR : SHDR;
      SHDR:    return m ? EX1DR : SHDR;
      EX1DR:   return m ? UPDDR : PAUSEDR;
      PAUSEDR: return m ? EX2DR : PAUSEDR;
      EX2DR:   return m ? UPDDR : SHDR;
      UPDDR:   return m ? SELDR : RTI;
      SELIR:   return m ? TLR   : CAPIR;
      CAPIR:   return m ? EX1IR : SHIR;
      SHIR:    return m ? EX1IR : SHIR;
      EX1IR:   return m ? UPDIR : PAUSEIR;
      PAUSEIR: return m ? EX2IR : PAUSEIR;
      EX2IR:   return m ? UPDIR : SHIR;
      default: return m ? SELDR : RTI;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] mask_of(input int n);
    logic [63:0] m;
    m = (n >= 64) ? '1 : ((64'd1 << n) - 64'd1);
    return m[DATA_W-1:0];
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    $display("FAIL %s: expected event did not occur", name);
  endtask

  // TAP model: react to tck rising edges like a real target would
  initial forever begin
    @(posedge tck);
    tms_log.push_back(tms);
    rise_t.push_back($time);
    tck_rises++;
    if (tap == SHDR || tap == SHIR) begin
      if (sh_cnt < DATA_W) sh_bits[sh_cnt] = tdi;
      sh_ir = (tap == SHIR);
      sh_cnt++;
    end
    tap = tap_next(tap, tms);
  end

  // target drives its next tdo bit after the falling tck edge
  initial forever begin
    @(negedge tck);
    if (tdo_mode == 1) tdo_r = 1'b1;
    else if (sh_cnt < DATA_W) tdo_r = tdo_pat[sh_cnt];
    else tdo_r = 1'b0;
  end

  initial forever begin
    @(posedge clk);
    #1;
    case (rdy_mode)
      0:       rsp_ready = ($urandom_range(0, 2) != 0);
      1:       rsp_ready = 1'b0;
      default: rsp_ready = 1'b1;
    endcase
  end

  // Monitor: timing on rsp_valid rise, data and TAP-side results on handshake
  initial begin
    logic prev_v;
    exp_t e;
    prev_v = 1'b0;
    forever begin
      @(negedge clk);
      if (rsp_valid && !prev_v) begin
        if (exp_q.size() == 0) fail_now("rsp_unexpected");
        else begin
          chk("scan_tcks", 64'(tck_rises - start_tck), 64'(exp_q[0].tcks));
          chk("scan_clks", 64'($time - start_t), 64'(2 * DIV * exp_q[0].tcks * CLK_P + CLK_P/2));
        end
      end
      if (rsp_valid && rsp_ready && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("rsp_data", 64'(rsp_data), 64'(e.rsp));
        chk("shift_count", 64'(sh_cnt), 64'(e.n));
        chk("shift_reg_ir", 64'(sh_ir), 64'(e.ir));
        chk("shift_tdi", 64'(sh_bits), 64'(e.tdi_bits));
        chk("tap_idle", 64'(tap), 64'(RTI));
      end
      prev_v = rsp_valid;
    end
  end

  task automatic issue(input bit ir, input int len, input logic [DATA_W-1:0] data,
                       input int mode, input logic [DATA_W-1:0] pat);
    exp_t e;
    int   n;
    int   g;
    n          = ((len > DATA_W - 1) ? DATA_W - 1 : len) + 1;
    e.n        = n;
    e.ir       = ir;
    e.tcks     = (ir ? 4 : 3) + n + 2;
    e.tdi_bits = data & mask_of(n);
    e.rsp      = (mode == 0) ? (data & mask_of(n)) :
                 (mode == 1) ? mask_of(n) : (pat & mask_of(n));
    tdo_mode = mode;
    tdo_pat  = pat;
    tdo_r    = (mode == 1) ? 1'b1 : pat[0];
    sh_cnt   = 0;
    sh_bits  = '0;
    sh_ir    = 1'b0;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    cmd_valid = 1'b1;
    cmd_ir    = ir;
    cmd_len   = LEN_W'(len);
    cmd_data  = data;
    g = 0;
    @(negedge clk);
    while (!cmd_ready && g < 500) begin
      @(negedge clk);
      g++;
    end
    if (!cmd_ready) begin
      fail_now("cmd_accept");
      exp_q.delete();
    end else begin
      @(posedge clk);
      start_t   = $time;
      start_tck = tck_rises;
    end
    #1;
    cmd_valid = 1'b0;
    cmd_data  = DATA_W'({$urandom, $urandom});
  endtask

  task automatic wait_done();
    int g = 0;
    while (exp_q.size() != 0 && g < 2000) begin
      @(negedge clk);
      g++;
    end
    if (exp_q.size() != 0) begin
      fail_now("rsp_timeout");
      exp_q.delete();
    end
  endtask

  task automatic init_check();
    int          n;
    bit          seen_v;
    logic [63:0] v;
    tms_log.delete();
    rise_t.delete();
    seen_v = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    n = 0;
    while (!cmd_ready && n < 200) begin
      @(posedge clk);
      #1;
      n++;
      if (rsp_valid) seen_v = 1'b1;
    end
    chk("init_clks", 64'(n), 64'd24);
    chk("init_tms_count", 64'(tms_log.size()), 64'd6);
    v = '0;
    foreach (tms_log[i]) if (i < 64) v[i] = tms_log[i];
    chk("init_tms_seq", v, 64'h1F);
    if (rise_t.size() >= 2) chk("tck_period", 64'(rise_t[1] - rise_t[0]), 64'(2 * DIV * CLK_P));
    else fail_now("tck_period");
    chk("init_rsp_valid", 64'(seen_v), 64'd0);
    chk("init_tap_idle", 64'(tap), 64'(RTI));
  endtask

  initial begin
    logic [63:0]       v;
    logic [63:0]       r;
    logic [DATA_W-1:0] held;
    int                bad;
    int                g;

    #12;
    chk("reset_tck", 64'(tck), 64'd0);
    chk("reset_tms", 64'(tms), 64'd1);
    chk("reset_tdi", 64'(tdi), 64'd0);
    chk("reset_cmd_ready", 64'(cmd_ready), 64'd0);
    chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("reset_rsp_data", 64'(rsp_data), 64'd0);
    init_check();

    // IR loopback, 2 bits
    rdy_mode = 2;
    tms_log.delete();
    issue(1'b1, 1, 38'h2, 0, '0);
    wait_done();
    chk("ir_tms_count", 64'(tms_log.size()), 64'd8);
    v = '0;
    foreach (tms_log[i]) if (i < 64) v[i] = tms_log[i];
    chk("ir_tms_seq", v, 64'h63);

    // full-width DR loopback and clamped length with tdo stuck at 1
    issue(1'b0, 37, 38'h2A5555AAAA, 0, '0);
    wait_done();
    issue(1'b0, 63, 38'h0123456789, 1, '0);
    wait_done();

    // response held back for 50 clk
    rdy_mode = 1;
    r = {$urandom, $urandom};
    issue(1'b0, 20, r[DATA_W-1:0], 2, 38'h15A5A5C3C3);
    g = 0;
    while (!rsp_valid && g < 1000) begin
      @(negedge clk);
      g++;
    end
    if (!rsp_valid) fail_now("hold_rsp_valid");
    held = rsp_data;
    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (!rsp_valid || rsp_data !== held || cmd_ready || tck) bad++;
    end
    chk("hold_stable", 64'(bad), 64'd0);
    rdy_mode = 2;
    g = 0;
    @(negedge clk);
    while (!(rsp_valid && rsp_ready) && g < 10) begin
      @(negedge clk);
      g++;
    end
    @(negedge clk);
    chk("release_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("release_cmd_ready", 64'(cmd_ready), 64'd1);
    wait_done();

    // asynchronous reset in the middle of a shift
    rdy_mode = 0;
    r = {$urandom, $urandom};
    issue(1'b0, 37, r[DATA_W-1:0], 2, 38'h3C0FF0A55A);
    g = 0;
    while (sh_cnt < 10 && g < 1000) begin
      @(negedge clk);
      g++;
    end
    if (sh_cnt < 10) fail_now("mid_shift_reached");
    #3;
    reset_n = 1'b0;
    #1;
    chk("arst_tck", 64'(tck), 64'd0);
    chk("arst_tms", 64'(tms), 64'd1);
    chk("arst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("arst_cmd_ready", 64'(cmd_ready), 64'd0);
    chk("arst_rsp_data", 64'(rsp_data), 64'd0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    init_check();

    // randomised scans
    for (int k = 0; k < 25; k++) begin
      bit ir;
      int len;
      int mode;
      logic [63:0] d;
      logic [63:0] p;
      ir   = 1'($urandom_range(0, 1));
      len  = (k % 3 == 0) ? $urandom_range(0, 5) : $urandom_range(0, 63);
      mode = $urandom_range(0, 2);
      d    = {$urandom, $urandom};
      p    = {$urandom, $urandom};
      issue(ir, len, d[DATA_W-1:0], mode, p[DATA_W-1:0]);
      wait_done();
    end

    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
